// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction fetch sequencer: memory req/ack on one side, decoder valid/ready on the other.
// Optional link register enabled by defining PC_LINK_REG_EN (adds redirect_link_i / link_pc_o).
module pc_fetch_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             inst_valid_o,
    output logic [WIDTH-1:0] inst_data_o,
    output logic [WIDTH-1:0] inst_pc_o,
    input  logic             inst_ready_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             busy_o
`ifdef PC_LINK_REG_EN
    ,
    input  logic             redirect_link_i,
    output logic [WIDTH-1:0] link_pc_o
`endif
);

    // state | meaning
    // IDLE  | not fetching; redirects only update pc
    // FETCH | request outstanding for a fetch whose data will be used
    // KILL  | request outstanding whose data is discarded after a redirect
    // ISSUE | instruction presented to the decoder
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_KILL  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] issue_next_pc;
`ifdef PC_LINK_REG_EN
    logic [WIDTH-1:0] link_q, link_d;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ipc_q   <= '0;
            busy_q  <= 1'b0;
`ifdef PC_LINK_REG_EN
            link_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
            busy_q  <= busy_d;
`ifdef PC_LINK_REG_EN
            link_q  <= link_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                if (redirect_valid_i && !imem_ack_i) state_d = S_KILL;
                else if (imem_ack_i && !redirect_valid_i) state_d = S_ISSUE;
            end
            S_KILL:  if (imem_ack_i) state_d = S_FETCH;
            S_ISSUE: begin
                if (inst_ready_i || redirect_valid_i) state_d = halt_i ? S_IDLE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A redirect seen in ISSUE always ends the current instruction, consumed or squashed.
    assign issue_next_pc = redirect_valid_i ? redirect_pc_i : pc_q;

    always_comb begin
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
`ifdef PC_LINK_REG_EN
        link_d  = link_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                if (start_i) begin
                    req_d  = 1'b1;
                    addr_d = redirect_valid_i ? redirect_pc_i : pc_q;
                end
            end
            S_FETCH: begin
                if (imem_ack_i && !redirect_valid_i) begin
                    data_d  = imem_rdata_i;
                    ipc_d   = addr_q;
                    pc_d    = addr_q + 1'b1;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                    if (imem_ack_i) addr_d = redirect_pc_i;
                end
            end
            S_KILL: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                if (imem_ack_i) addr_d = redirect_valid_i ? redirect_pc_i : pc_q;
            end
            S_ISSUE: begin
                if (inst_ready_i || redirect_valid_i) begin
                    valid_d = 1'b0;
                    pc_d    = issue_next_pc;
                    if (!halt_i) begin
                        req_d  = 1'b1;
                        addr_d = issue_next_pc;
                    end
                end
`ifdef PC_LINK_REG_EN
                if (redirect_valid_i && redirect_link_i) link_d = ipc_q + 1'b1;
`endif
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = valid_q;
    assign inst_data_o  = data_q;
    assign inst_pc_o    = ipc_q;
    assign pc_o         = pc_q;
    assign busy_o       = busy_q;
`ifdef PC_LINK_REG_EN
    assign link_pc_o    = link_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a randomized run against a stream-level model.
module tb_pc_fetch_sequencer;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, halt_i, redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_data_o, inst_pc_o;
    logic        inst_ready_i;
    logic [31:0] pc_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pc_fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .halt_i(halt_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_data_o(inst_data_o), .inst_pc_o(inst_pc_o),
        .inst_ready_i(inst_ready_i), .pc_o(pc_o), .busy_o(busy_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        reset_i = 0; start_i = 0; halt_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
        imem_ack_i = 0; imem_rdata_i = 0; inst_ready_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_i = 1; start_i = 1;
        step();
        clear_inputs();
        n_cmp++;
        if ({imem_req_o, inst_valid_o, busy_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got req/valid/busy=%b want 000", {imem_req_o, inst_valid_o, busy_o});
        end
        n_cmp++;
        if ({imem_addr_o, inst_data_o, inst_pc_o, pc_o} !== 128'd0) begin
            n_err++; $display("FAIL reset_regs: got addr=%h data=%h ipc=%h pc=%h want all 0", imem_addr_o, inst_data_o, inst_pc_o, pc_o);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int last = 0;
        start_i = 1; step(); start_i = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            imem_ack_i   = imem_req_o;
            imem_rdata_i = imem_addr_o ^ K;
            inst_ready_i = 1;
            halt_i       = (n == 3);
            if (inst_valid_o) begin
                n_cmp++;
                if (inst_pc_o !== n || inst_data_o !== (n ^ K)) begin
                    n_err++; $display("FAIL stream_inst%0d: got pc=%h data=%h want pc=%h data=%h", n, inst_pc_o, inst_data_o, n, n ^ K);
                end
                if (n > 0) begin
                    n_cmp++;
                    if (cyc - last != 2) begin
                        n_err++; $display("FAIL stream_rate: got %0d cycles want 2", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            step();
        end
        clear_inputs();
        n_cmp++;
        if (n != 4) begin
            n_err++; $display("FAIL stream_count: got %0d instructions want 4", n);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || pc_o !== 32'd4 || imem_req_o !== 1'b0) begin
            n_err++; $display("FAIL stream_halt: got busy=%b pc=%h req=%b want 0/4/0", busy_o, pc_o, imem_req_o);
        end
    endtask

    task automatic test_wait_state();
        start_i = 1; step(); start_i = 0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({imem_req_o, inst_valid_o} !== 2'b10 || imem_addr_o !== 32'd4) begin
                n_err++; $display("FAIL wait_hold%0d: got req/valid=%b addr=%h want 10 addr=4", c, {imem_req_o, inst_valid_o}, imem_addr_o);
            end
            imem_ack_i   = (c == 2);
            imem_rdata_i = imem_addr_o ^ K;
            step();
        end
        imem_ack_i = 0;
        n_cmp++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'd4 || inst_data_o !== (32'd4 ^ K) || imem_req_o !== 1'b0) begin
            n_err++; $display("FAIL wait_issue: got valid=%b pc=%h data=%h req=%b want 1/4/%h/0", inst_valid_o, inst_pc_o, inst_data_o, imem_req_o, 32'd4 ^ K);
        end
        inst_ready_i = 1; halt_i = 1; step(); clear_inputs();
        n_cmp++;
        if (busy_o !== 1'b0 || pc_o !== 32'd5) begin
            n_err++; $display("FAIL wait_halt: got busy=%b pc=%h want 0/5", busy_o, pc_o);
        end
    endtask

    task automatic test_kill();
        start_i = 1; step(); start_i = 0;
        redirect_valid_i = 1; redirect_pc_i = 32'h100; step(); clear_inputs();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd5 || pc_o !== 32'h100) begin
            n_err++; $display("FAIL kill_enter: got req=%b addr=%h pc=%h want 1/5/100", imem_req_o, imem_addr_o, pc_o);
        end
        imem_ack_i = 1; imem_rdata_i = 32'd5 ^ K; step(); clear_inputs();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL kill_refetch: got req=%b addr=%h valid=%b want 1/100/0", imem_req_o, imem_addr_o, inst_valid_o);
        end
        imem_ack_i = 1; imem_rdata_i = 32'h100 ^ K; step(); clear_inputs();
        n_cmp++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100 || inst_data_o !== (32'h100 ^ K)) begin
            n_err++; $display("FAIL kill_issue: got valid=%b pc=%h data=%h want 1/100/%h", inst_valid_o, inst_pc_o, inst_data_o, 32'h100 ^ K);
        end
    endtask

    task automatic test_issue_redirect();
        inst_ready_i = 1; step(); clear_inputs();
        redirect_valid_i = 1; redirect_pc_i = 32'd7; imem_ack_i = 1; imem_rdata_i = 32'h101 ^ K;
        step(); clear_inputs();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd7 || inst_valid_o !== 1'b0 || pc_o !== 32'd7) begin
            n_err++; $display("FAIL redir_ack: got req=%b addr=%h valid=%b pc=%h want 1/7/0/7", imem_req_o, imem_addr_o, inst_valid_o, pc_o);
        end
        imem_ack_i = 1; imem_rdata_i = 32'd7 ^ K; step(); clear_inputs();
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'd7 || inst_data_o !== (32'd7 ^ K)) begin
                n_err++; $display("FAIL issue_hold%0d: got valid=%b pc=%h data=%h want 1/7/%h", c, inst_valid_o, inst_pc_o, inst_data_o, 32'd7 ^ K);
            end
            step();
        end
        redirect_valid_i = 1; redirect_pc_i = 32'h40; step(); clear_inputs();
        n_cmp++;
        if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || pc_o !== 32'h40) begin
            n_err++; $display("FAIL squash: got valid=%b req=%b addr=%h pc=%h want 0/1/40/40", inst_valid_o, imem_req_o, imem_addr_o, pc_o);
        end
        imem_ack_i = 1; imem_rdata_i = 32'h40 ^ K; step(); clear_inputs();
        n_cmp++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h40) begin
            n_err++; $display("FAIL squash_next: got valid=%b pc=%h want 1/40", inst_valid_o, inst_pc_o);
        end
        redirect_valid_i = 1; redirect_pc_i = 32'h60; inst_ready_i = 1; step(); clear_inputs();
        n_cmp++;
        if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h60) begin
            n_err++; $display("FAIL consume_redir: got valid=%b req=%b addr=%h want 0/1/60", inst_valid_o, imem_req_o, imem_addr_o);
        end
        imem_ack_i = 1; imem_rdata_i = 32'h60 ^ K; step(); clear_inputs();
        inst_ready_i = 1; halt_i = 1; step(); clear_inputs();
        n_cmp++;
        if (busy_o !== 1'b0 || pc_o !== 32'h61) begin
            n_err++; $display("FAIL consume_halt: got busy=%b pc=%h want 0/61", busy_o, pc_o);
        end
    endtask

    task automatic test_wrap();
        redirect_valid_i = 1; redirect_pc_i = 32'h123; step(); clear_inputs();
        halt_i = 1; step(); clear_inputs();
        n_cmp++;
        if (busy_o !== 1'b0 || imem_req_o !== 1'b0 || pc_o !== 32'h123) begin
            n_err++; $display("FAIL idle_redir: got busy=%b req=%b pc=%h want 0/0/123", busy_o, imem_req_o, pc_o);
        end
        start_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFF; step(); clear_inputs();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL start_redir: got req=%b addr=%h want 1/ffffffff", imem_req_o, imem_addr_o);
        end
        imem_ack_i = 1; imem_rdata_i = 32'hFFFF_FFFF ^ K; step(); clear_inputs();
        n_cmp++;
        if (inst_pc_o !== 32'hFFFF_FFFF || inst_data_o !== (32'hFFFF_FFFF ^ K) || pc_o !== 32'd0) begin
            n_err++; $display("FAIL wrap_top: got ipc=%h data=%h pc=%h want ffffffff/%h/0", inst_pc_o, inst_data_o, pc_o, 32'hFFFF_FFFF ^ K);
        end
        inst_ready_i = 1; step(); clear_inputs();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0) begin
            n_err++; $display("FAIL wrap_fetch: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o);
        end
        imem_ack_i = 1; imem_rdata_i = K; step(); clear_inputs();
        inst_ready_i = 1; halt_i = 1; step(); clear_inputs();
        n_cmp++;
        if (busy_o !== 1'b0 || pc_o !== 32'd1 || inst_valid_o !== 1'b0 || inst_pc_o !== 32'd0) begin
            n_err++; $display("FAIL wrap_halt: got busy=%b pc=%h valid=%b ipc=%h want 0/1/0/0", busy_o, pc_o, inst_valid_o, inst_pc_o);
        end
    endtask

    task automatic test_reset_mid_kill();
        start_i = 1; step(); clear_inputs();
        redirect_valid_i = 1; redirect_pc_i = 32'h200; step(); clear_inputs();
        reset_i = 1; imem_ack_i = 1; imem_rdata_i = K; step();
        reset_i = 0;
        n_cmp++;
        if (imem_req_o !== 1'b0 || pc_o !== 32'd0 || inst_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_kill: got req=%b pc=%h valid=%b busy=%b want 0/0/0/0", imem_req_o, pc_o, inst_valid_o, busy_o);
        end
        step(); clear_inputs();
        n_cmp++;
        if (inst_valid_o !== 1'b0 || busy_o !== 1'b0 || pc_o !== 32'd0) begin
            n_err++; $display("FAIL stale_ack: got valid=%b busy=%b pc=%h want 0/0/0", inst_valid_o, busy_o, pc_o);
        end
    endtask

    // Model: every newly presented instruction carries the architectural next address,
    // which advances by one per presented instruction and is overridden by any redirect.
    task automatic test_random();
        logic [31:0] exp_next = 32'd0;
        logic [31:0] prev_addr = 0, prev_ipc = 0, prev_data = 0;
        bit prev_valid = 0, hold_req = 0, hold_inst = 0, squash = 0, pending = 0;
        int lat = 0;
        int delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold_req) begin
                n_cmp++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
                    n_err++; $display("FAIL rnd_req_hold@%0d: got req=%b addr=%h want 1/%h", c, imem_req_o, imem_addr_o, prev_addr);
                end
            end
            if (hold_inst) begin
                n_cmp++;
                if (inst_valid_o !== 1'b1 || inst_pc_o !== prev_ipc || inst_data_o !== prev_data) begin
                    n_err++; $display("FAIL rnd_inst_hold@%0d: got valid=%b pc=%h data=%h want 1/%h/%h", c, inst_valid_o, inst_pc_o, inst_data_o, prev_ipc, prev_data);
                end
            end
            if (squash) begin
                n_cmp++;
                if (inst_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL rnd_squash@%0d: got valid=%b want 0", c, inst_valid_o);
                end
            end
            if (inst_valid_o && !prev_valid) begin
                n_cmp++;
                if (inst_pc_o !== exp_next || inst_data_o !== (exp_next ^ K) || pc_o !== exp_next + 32'd1) begin
                    n_err++; $display("FAIL rnd_inst@%0d: got pc=%h data=%h arch=%h want %h/%h/%h", c, inst_pc_o, inst_data_o, pc_o, exp_next, exp_next ^ K, exp_next + 32'd1);
                end
                exp_next = exp_next + 32'd1;
                delivered++;
            end
            start_i          = !busy_o && ($urandom_range(3) == 0);
            redirect_valid_i = ($urandom_range(9) == 0);
            redirect_pc_i    = $urandom;
            inst_ready_i     = $urandom_range(1);
            halt_i           = ($urandom_range(15) == 0);
            if (imem_req_o && !pending) begin
                pending = 1;
                lat = $urandom_range(3);
            end
            imem_ack_i = 0;
            if (pending) begin
                if (lat == 0) begin
                    imem_ack_i = 1;
                    pending = 0;
                end else begin
                    lat--;
                end
            end
            imem_rdata_i = imem_ack_i ? (imem_addr_o ^ K) : $urandom;
            hold_req   = imem_req_o && !imem_ack_i;
            hold_inst  = inst_valid_o && !inst_ready_i && !redirect_valid_i;
            squash     = inst_valid_o && redirect_valid_i;
            prev_valid = inst_valid_o;
            prev_addr  = imem_addr_o;
            prev_ipc   = inst_pc_o;
            prev_data  = inst_data_o;
            if (redirect_valid_i) exp_next = redirect_pc_i;
            step();
        end
        clear_inputs();
        n_cmp++;
        if (delivered < 20) begin
            n_err++; $display("FAIL rnd_progress: got %0d instructions want at least 20", delivered);
        end
    endtask

    initial begin
        clear_inputs();
        reset_i = 1;
        test_reset();
        test_stream();
        test_wait_state();
        test_kill();
        test_issue_redirect();
        test_wrap();
        test_reset_mid_kill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
